gpio_bus_arbiter: RTL

Shares the single memory-mapped GPIO slave port between two bus masters: m0 (CPU data port) and m1 (debug/host master). Round-robin arbitration, one transaction per grant. Drives the slave address, write-data and write-enable lines. Generates its own read-valid and routes read data back to the owning master, using the slave's fixed registered read latency.

---
 rtl/gpio_bus_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/gpio_bus_arbiter.sv
// Round-robin share of one GPIO slave port between m0 and m1; grant is combinational in IDLE.
// Write takes 2 cycles, read returns rvalid READ_LATENCY+2 cycles after grant; losers hold req.
module gpio_bus_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] gpio_address,
  output logic [DATA_W-1:0] gpio_data_write,
  output logic              gpio_write_enable,
  input  logic [DATA_W-1:0] gpio_data_read
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic               last_q;
  logic               own_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               m0_rvalid_q, m1_rvalid_q;
  logic [DATA_W-1:0]  m0_rdata_q, m1_rdata_q;

  logic grant;
  logic win;
  logic cap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    win     = 1'b0;
    cap     = 1'b0;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (m0_req && m1_req) begin
          grant = 1'b1;
          win   = ~last_q;
        end else if (m0_req) begin
          grant = 1'b1;
          win   = 1'b0;
        end else if (m1_req) begin
          grant = 1'b1;
          win   = 1'b1;
        end
        if (grant) begin
          m0_gnt  = ~win;
          m1_gnt  = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          cap     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= cap & ~own_q;
      m1_rvalid_q <= cap & own_q;
      if (grant) begin
        own_q   <= win;
        last_q  <= win;
        we_q    <= win ? m1_we    : m0_we;
        addr_q  <= win ? m1_addr  : m0_addr;
        wdata_q <= win ? m1_wdata : m0_wdata;
      end
      if (cap && !own_q) m0_rdata_q <= gpio_data_read;
      if (cap && own_q)  m1_rdata_q <= gpio_data_read;
    end
  end

  // Address and write data stay on the last issued values between transactions.
  assign gpio_address      = addr_q;
  assign gpio_data_write   = wdata_q;
  assign gpio_write_enable = (state_q == ISSUE) && we_q;

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
